line_mem_responder: RTL and testbench
=====================================

Name: line_mem_responder

Overview:
Responder end of the line-granular memory protocol that the cache uses for swap-in and swap-out. It accepts one line read or line write at a time and moves the line one word per cycle through a word-wide backing array. It adds a parameterised access latency and signals completion with a single-cycle gnt pulse. It is the drop-in backing store behind the cache in the memory-hierarchy testbenches.

Parameters:
LINE_ADDR_LEN, 3, log2 of words per line (LINE_SIZE = 1<<LINE_ADDR_LEN)
ADDR_LEN, 9, line-address width; array holds 2^(ADDR_LEN+LINE_ADDR_LEN) 32-bit words
RD_LATENCY, 4, wait cycles inserted before a read transfer (0 allowed)
WR_LATENCY, 4, wait cycles inserted before a write transfer (0 allowed)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
addr  in  ADDR_LEN  line address of request
rd_req  in  1  line read request, level, held until gnt
wr_req  in  1  line write request, level, held until gnt
wr_line  in  32 x LINE_SIZE  line to write, sampled at acceptance
rd_line  out  32 x LINE_SIZE  last line read
gnt  out  1  completion pulse, one cycle
busy  out  1  high in any state except IDLE

Behaviour:
- States: IDLE, WAIT, XFER, DONE. Word counter width LINE_ADDR_LEN. Wait counter width is sized for max(RD_LATENCY, WR_LATENCY).
- IDLE: if wr_req or rd_req is sampled high at a clock edge, latch addr, op and wr_line into internal buffers.
  - wr_req has priority when both are high; only the write is performed and the read is not queued.
  - Next state is WAIT with count = latency of op, or XFER directly if that latency is 0.
- WAIT: lasts exactly latency cycles, then XFER with word index 0.
- XFER: lasts exactly LINE_SIZE cycles; word k is handled in the k-th XFER cycle.
  - Write: array[{latched addr, k}] <= wr_buf[k].
  - Read: rd_line[k] <= array[{latched addr, k}]. The array read is asynchronous.
  - After word LINE_SIZE-1, go to DONE.
- DONE: gnt = 1 for this cycle only; next state IDLE.
  - A new request can first be accepted in the cycle after DONE.
  - This makes the requester pattern "gnt, then drop wr_req and raise rd_req the next cycle" work with no lost cycle.
- Latency: request first high in cycle 0 (state IDLE) gives gnt in cycle latency + LINE_SIZE + 1. With defaults this is cycle 13; with latency 0 it is cycle 9.
- rd_line during a read XFER is partially updated. It is valid and stable from the DONE cycle until the next read's XFER begins. Writes never modify rd_line.
- Address or request changes after acceptance are ignored. A request dropped mid-operation does not abort it; gnt still pulses.
- Reset values: gnt 0, busy 0, rd_line all 0, state IDLE, counters 0.
- Reset mid-operation: abort immediately, no gnt. Array words already written stay written and the remaining words are unchanged, so a partial line is possible.
- Array contents are not cleared by rst. They are initialised to 0 at time zero.

Decomposition:
- Package line_mem_pkg holds:
  - state enum {IDLE, WAIT, XFER, DONE};
  - op enum {OP_RD, OP_WR};
  - localparams LINE_SIZE and MEM_WORDS as functions of the parameters.
- One sub-module, line_word_ram: word-addressed array with asynchronous read and synchronous write, single port, 32-bit, 2^(ADDR_LEN+LINE_ADDR_LEN) deep, zero-initialised.

Test Plan:
1. Write addr 0x005 with word i = 0x1000+i, then read 0x005 in the cycle after gnt. Each gnt arrives 13 cycles after its request; rd_line[i] = 0x1000+i; busy high between request and gnt.
2. Read never-written addr 0x1FF. gnt at cycle 13; rd_line all 0x0.
3. rd_req and wr_req both high, addr 0x010, wr_line word i = 0xA0+i. Exactly one gnt; rd_line unchanged. A subsequent read of 0x010 returns 0xA0+i.
4. Pulse rst during the 3rd XFER cycle of a write to 0x020 (words 0xB0+i) over a prior all-zero line. No gnt; state IDLE; busy 0. Reading 0x020 returns words 0..1 = 0xB0, 0xB1 and words 2..7 = 0.
5. Rebuild with RD_LATENCY = 0 and WR_LATENCY = 2. Read gnt at cycle 9 and write gnt at cycle 11 after the request. Back-to-back write then read gives two gnt pulses with no idle gap beyond the single DONE-to-IDLE cycle.
6. Drop rd_req after 2 cycles of a read of 0x005. Op completes; gnt pulses once at cycle 13; rd_line holds the 0x005 data. No further gnt while requests stay low.

Source files
------------

// File: rtl/line_mem_responder_pkg.sv
// Shared types and sizing helpers for the line memory responder.
// No ports. Sizes depend on module parameters, so they are provided as
// functions; the localparams give the sizes for the default configuration.
package line_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;

  localparam int DEF_LINE_ADDR_LEN = 3;
  localparam int DEF_ADDR_LEN      = 9;

  function automatic int line_size(input int line_addr_len);
    return 1 << line_addr_len;
  endfunction

  function automatic int mem_words(input int addr_len, input int line_addr_len);
    return 1 << (addr_len + line_addr_len);
  endfunction

  // The wait counter is loaded with latency-1, so it only has to hold
  // max(latency)-1; never narrower than one bit.
  function automatic int wait_cnt_w(input int rd_lat, input int wr_lat);
    int mx;
    mx = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return (mx <= 2) ? 1 : $clog2(mx);
  endfunction

  localparam int LINE_SIZE = line_size(DEF_LINE_ADDR_LEN);
  localparam int MEM_WORDS = mem_words(DEF_ADDR_LEN, DEF_LINE_ADDR_LEN);

endpackage

// File: rtl/line_mem_responder_if.sv
// Line-granular request/grant bus between a cache (master) and the
// backing store (slave).
//   addr    : line address of the request
//   rd_req  : line read request, level, held until gnt
//   wr_req  : line write request, level, held until gnt
//   wr_line : line to write, sampled when the request is accepted
//   rd_line : last line read
//   gnt     : one-cycle completion pulse
//   busy    : responder is working on a request
interface line_mem_responder_if
  import line_mem_pkg::*;
#(
  parameter int ADDR_LEN      = 9,
  parameter int LINE_ADDR_LEN = 3
);
  localparam int LS = line_size(LINE_ADDR_LEN);

  logic [ADDR_LEN-1:0]   addr;
  logic                  rd_req;
  logic                  wr_req;
  logic [LS-1:0][31:0]   wr_line;
  logic [LS-1:0][31:0]   rd_line;
  logic                  gnt;
  logic                  busy;

  modport master (
    output addr, rd_req, wr_req, wr_line,
    input  rd_line, gnt, busy
  );

  modport slave (
    input  addr, rd_req, wr_req, wr_line,
    output rd_line, gnt, busy
  );
endinterface

// File: rtl/line_word_ram.sv
// Word-addressed 32-bit backing array, single port, asynchronous read,
// synchronous write. Contents start at zero and are not touched by reset.
//   clk   : clock
//   we    : write enable
//   addr  : word address (shared by read and write)
//   wdata : write data
//   rdata : combinational read data at addr
module line_word_ram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [1 << AW] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/line_mem_responder.sv
// Responder for line reads/writes: accepts one request at a time, waits a
// per-operation latency, then moves the line one word per cycle through
// the word RAM and pulses gnt for one cycle.
//   clk : clock
//   rst : asynchronous, active-high reset (RAM contents are kept)
//   bus : line_mem_responder_if slave port (addr, rd_req, wr_req, wr_line,
//         rd_line, gnt, busy)
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9,
  parameter int RD_LATENCY    = 4,
  parameter int WR_LATENCY    = 4
) (
  input  logic clk,
  input  logic rst,
  line_mem_responder_if.slave bus
);

  localparam int LS = line_size(LINE_ADDR_LEN);
  localparam int AW = ADDR_LEN + LINE_ADDR_LEN;
  localparam int WW = wait_cnt_w(RD_LATENCY, WR_LATENCY);
  localparam logic [WW-1:0] RD_LOAD = WW'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);
  localparam logic [WW-1:0] WR_LOAD = WW'((WR_LATENCY > 0) ? WR_LATENCY - 1 : 0);

  state_t                   state, state_nx;
  op_t                      op_q, op_in;
  logic [ADDR_LEN-1:0]      addr_q;
  logic [LS-1:0][31:0]      wr_buf;
  logic [LS-1:0][31:0]      rd_q;
  logic [LINE_ADDR_LEN-1:0] word_cnt;
  logic [WW-1:0]            wait_cnt;
  logic                     req_in;
  logic                     lat_zero;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;

  // Write wins when both requests are up; the read is simply dropped.
  assign req_in   = bus.wr_req | bus.rd_req;
  assign op_in    = bus.wr_req ? OP_WR : OP_RD;
  assign lat_zero = (op_in == OP_WR) ? (WR_LATENCY == 0) : (RD_LATENCY == 0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_in) state_nx = lat_zero ? XFER : WAIT;
      WAIT: if (wait_cnt == '0) state_nx = XFER;
      XFER: if (word_cnt == '1) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= OP_RD;
      addr_q   <= '0;
      wr_buf   <= '0;
      rd_q     <= '0;
      word_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req_in) begin
            op_q     <= op_in;
            addr_q   <= bus.addr;
            wr_buf   <= bus.wr_line;
            word_cnt <= '0;
            wait_cnt <= (op_in == OP_WR) ? WR_LOAD : RD_LOAD;
          end
        end
        WAIT: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
        end
        XFER: begin
          if (op_q == OP_RD) rd_q[word_cnt] <= ram_rdata;
          word_cnt <= word_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A reset during XFER stops writes at once; earlier words stay written.
  assign ram_we   = (state == XFER) && (op_q == OP_WR);
  assign ram_addr = {addr_q, word_cnt};

  line_word_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wr_buf[word_cnt]),
    .rdata (ram_rdata)
  );

  assign bus.rd_line = rd_q;
  assign bus.gnt     = (state == DONE);
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench: requesters push expected (gnt cycle, rd_line) pairs,
// monitors pop and compare on every gnt. dut_a uses default latencies,
// dut_b uses RD_LATENCY=0, WR_LATENCY=2.
module tb_line_mem_responder;
  import line_mem_pkg::*;

  typedef logic [7:0][31:0] line_t;
  typedef struct {
    int    cyc;
    line_t line;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  line_mem_responder_if #(.ADDR_LEN(9), .LINE_ADDR_LEN(3)) bus_a();
  line_mem_responder_if #(.ADDR_LEN(9), .LINE_ADDR_LEN(3)) bus_b();

  line_mem_responder #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .RD_LATENCY(4), .WR_LATENCY(4))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

  line_mem_responder #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .RD_LATENCY(0), .WR_LATENCY(2))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic line_t mk(input logic [31:0] base);
    line_t l;
    for (int i = 0; i < 8; i++) l[i] = base + 32'(i);
    return l;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus_a.gnt) begin
      if (q_a.size() == 0) chk("a_unexpected_gnt", 256'(bus_a.gnt), 256'(0));
      else begin
        e = q_a.pop_front();
        chk("a_gnt_cycle", 256'(cyc), 256'(e.cyc));
        chk("a_rd_line", bus_a.rd_line, e.line);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus_b.gnt) begin
      if (q_b.size() == 0) chk("b_unexpected_gnt", 256'(bus_b.gnt), 256'(0));
      else begin
        e = q_b.pop_front();
        chk("b_gnt_cycle", 256'(cyc), 256'(e.cyc));
        chk("b_rd_line", bus_b.rd_line, e.line);
      end
    end
  end

  // One request on dut_a; hold < 0 keeps the request up until gnt.
  task automatic run_a(input bit w, input bit r, input logic [8:0] a, input line_t wl,
                       input line_t exp_rd, input int hold);
    int c;
    bit busy_ok;
    bit got;
    @(posedge clk);
    #1;
    c = cyc;
    q_a.push_back('{c + 13, exp_rd});
    bus_a.addr    = a;
    bus_a.wr_req  = w;
    bus_a.rd_req  = r;
    bus_a.wr_line = wl;
    busy_ok = 1'b1;
    got     = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (n == 0) chk("a_busy_accept_cycle", 256'(bus_a.busy), 256'(0));
      else if (!bus_a.busy) busy_ok = 1'b0;
      if (bus_a.gnt) got = 1'b1;
      if (got || (hold >= 0 && n + 1 >= hold)) begin
        bus_a.wr_req = 1'b0;
        bus_a.rd_req = 1'b0;
      end
    end
    chk("a_busy_during_op", 256'(busy_ok), 256'(1));
    if (!got) chk("a_gnt_timeout", 256'(got), 256'(1));
  endtask

  task automatic wait_gnt_b(output int g);
    bit got;
    got = 1'b0;
    g   = -1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (bus_b.gnt) begin
        got = 1'b1;
        g   = cyc;
      end
    end
    if (!got) chk("b_gnt_timeout", 256'(got), 256'(1));
  endtask

  initial begin
    int c, g1, g2;
    line_t part;
    bus_a.addr = '0; bus_a.rd_req = 1'b0; bus_a.wr_req = 1'b0; bus_a.wr_line = '0;
    bus_b.addr = '0; bus_b.rd_req = 1'b0; bus_b.wr_req = 1'b0; bus_b.wr_line = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt_a", 256'(bus_a.gnt), 256'(0));
    chk("reset_busy_a", 256'(bus_a.busy), 256'(0));
    chk("reset_rd_line_a", bus_a.rd_line, 256'(0));
    chk("reset_busy_b", 256'(bus_b.busy), 256'(0));
    rst = 1'b0;

    // write 0x005 then read it back in the cycle after gnt
    run_a(1'b1, 1'b0, 9'h005, mk(32'h1000), '0, -1);
    run_a(1'b0, 1'b1, 9'h005, '0, mk(32'h1000), -1);
    @(posedge clk);
    #1;
    chk("a_busy_after_gnt", 256'(bus_a.busy), 256'(0));

    // both requests: write wins, rd_line keeps previous read
    run_a(1'b1, 1'b1, 9'h010, mk(32'hA0), mk(32'h1000), -1);
    run_a(1'b0, 1'b1, 9'h010, '0, mk(32'hA0), -1);

    // never-written line reads as zero
    run_a(1'b0, 1'b1, 9'h1FF, '0, '0, -1);

    // reset during the third XFER cycle of a write to 0x020
    @(posedge clk);
    #1;
    c = cyc;
    bus_a.addr    = 9'h020;
    bus_a.wr_line = mk(32'hB0);
    bus_a.wr_req  = 1'b1;
    while (cyc < c + 7) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    bus_a.wr_req = 1'b0;
    #1;
    chk("rst_mid_busy", 256'(bus_a.busy), 256'(0));
    chk("rst_mid_gnt", 256'(bus_a.gnt), 256'(0));
    chk("rst_mid_state_idle", 256'(dut_a.state == IDLE), 256'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    part = '0;
    part[0] = 32'hB0;
    part[1] = 32'hB1;
    run_a(1'b0, 1'b1, 9'h020, '0, part, -1);

    // read dropped after 2 cycles still completes once
    run_a(1'b0, 1'b1, 9'h005, '0, mk(32'h1000), 2);
    repeat (20) @(negedge clk);

    // short-latency instance: write (lat 2) then read (lat 0) back to back
    @(posedge clk);
    #1;
    c = cyc;
    q_b.push_back('{c + 11, line_t'('0)});
    bus_b.addr    = 9'h033;
    bus_b.wr_line = mk(32'hC0);
    bus_b.wr_req  = 1'b1;
    wait_gnt_b(g1);
    @(posedge clk);
    #1;
    c = cyc;
    q_b.push_back('{c + 9, mk(32'hC0)});
    bus_b.wr_req = 1'b0;
    bus_b.rd_req = 1'b1;
    wait_gnt_b(g2);
    bus_b.rd_req = 1'b0;
    chk("b_gnt_gap", 256'(g2 - g1), 256'(10));

    repeat (5) @(negedge clk);
    chk("a_queue_drained", 256'(q_a.size()), 256'(0));
    chk("b_queue_drained", 256'(q_b.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1);
  end

endmodule
